// File: rtl/audio_pwm_out.sv
// audio_pwm_out: PWM audio DAC with a click-free 16-step gain envelope applied per PWM period
module audio_pwm_out #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] dacCount,
    input  logic         enable,
    output logic         pwmOut,
    output logic [N-1:0] duty,
    output logic [4:0]   gain,
    output logic         busy,
    output logic         periodStart
);
    typedef enum logic [1:0] {SILENT, RAMP_UP, PLAYING, RAMP_DOWN} state_t;
    localparam logic [4:0] GAIN_MAX = 5'd16;
    state_t       r_state, w_state_n;
    logic [N-1:0] r_cnt, r_duty;
    logic [4:0]   r_gain, w_gain_n, w_up, w_dn;
    logic         r_pwm, w_bnd;
    logic [N+4:0] w_prod;
    assign w_bnd       = r_cnt == {N{1'b1}};
    assign w_up        = r_gain + 5'd1;
    assign w_dn        = r_gain - 5'd1;
    assign w_prod      = {5'b0, dacCount} * {{N{1'b0}}, w_gain_n};
    assign pwmOut      = r_pwm;
    assign duty        = r_duty;
    assign gain        = r_gain;
    assign busy        = r_state != SILENT;
    assign periodStart = r_cnt == '0;
    // Envelope transitions; enable is only looked at on the last cycle of a period
    always_comb begin
        w_state_n = r_state;
        w_gain_n  = r_gain;
        if (w_bnd) begin
            case (r_state)
                SILENT: begin
                    w_gain_n  = enable ? 5'd1 : 5'd0;
                    w_state_n = enable ? RAMP_UP : SILENT;
                end
                PLAYING: begin
                    w_gain_n  = enable ? GAIN_MAX : GAIN_MAX - 5'd1;
                    w_state_n = enable ? PLAYING : RAMP_DOWN;
                end
                RAMP_UP, RAMP_DOWN: begin
                    w_gain_n  = enable ? w_up : w_dn;
                    w_state_n = enable ? (w_up == GAIN_MAX ? PLAYING : RAMP_UP)
                                       : (w_dn == 5'd0 ? SILENT : RAMP_DOWN);
                end
                default: begin
                    w_gain_n  = 5'd0;
                    w_state_n = SILENT;
                end
            endcase
        end
    end
    // Period counter, envelope state and duty latch (duty loads as cnt wraps to 0)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_state <= SILENT;
            r_gain  <= '0;
            r_duty  <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= w_state_n;
            r_gain  <= w_gain_n;
            r_pwm   <= r_cnt < r_duty;
            if (w_bnd)
                r_duty <= N'(w_prod >> 4);
        end
    end
endmodule

// File: doc/audio_pwm_out.md
AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 SHALL provide parameter N, default 7, meaning the sample width in bits and the PWM resolution (period = 2^N clk cycles).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port dacCount, input, N bits: unsigned sample from the sound generator.
REQ-005 SHALL have port enable, input, 1 bit: sound-request level (playSound).
REQ-006 SHALL have port pwmOut, output, 1 bit: registered PWM audio output.
REQ-007 SHALL have port duty, output, N bits: the duty value currently in effect.
REQ-008 SHALL have port gain, output, 5 bits: the current envelope gain (0..16).
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not SILENT.
REQ-010 SHALL have port periodStart, output, 1 bit: high exactly when the period counter equals 0.

Function
REQ-011 SHALL keep a free-running N-bit period counter cnt that increments every cycle and wraps from 2^N-1 to 0.
REQ-012 SHALL define a boundary cycle as any cycle with cnt == 2^N-1; state, gain and duty update only on boundary cycles.
REQ-013 SHALL implement the states SILENT, RAMP_UP, PLAYING and RAMP_DOWN, with enable sampled on boundary cycles only.
REQ-014 SILENT: enable=1 -> RAMP_UP with gain 1; otherwise remain SILENT with gain 0.
REQ-015 RAMP_UP: enable=1 -> gain+1, entering PLAYING when the new gain is 16; enable=0 -> gain-1 into RAMP_DOWN, or into SILENT if the new gain is 0.
REQ-016 PLAYING: enable=1 -> remain PLAYING with gain 16; enable=0 -> RAMP_DOWN with gain 15.
REQ-017 RAMP_DOWN: enable=0 -> gain-1, entering SILENT when the new gain is 0; enable=1 -> gain+1 into RAMP_UP, or into PLAYING if the new gain is 16.
REQ-018 On each boundary, duty SHALL load (dacCount * new_gain) >> 4, using an (N+5)-bit intermediate product and truncating to N bits; the result never overflows because gain <= 16.
REQ-019 The new duty SHALL take effect from the cycle where cnt == 0; changes to dacCount or enable mid-period SHALL NOT affect the current period.
REQ-020 pwmOut SHALL be registered as (cnt < duty), evaluated each cycle, giving one cycle of latency relative to cnt.
REQ-021 duty == 0 SHALL give pwmOut constantly 0; duty == 2^N-1 SHALL give 2^N-1 high cycles per period.
REQ-022 gain SHALL never leave the range 0..16, and no state SHALL be reachable other than the four listed.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set cnt=0, state=SILENT, gain=0, duty=0 and pwmOut=0.
REQ-024 busy SHALL be 0 and periodStart SHALL be 1 in the first cycle after reset is released.
REQ-025 Reset asserted in any state, mid-ramp or mid-period, SHALL abort the operation fully with no residual ramp.

Verification (N=7, period 128)
REQ-026 Reset: apply rst for 2 cycles, then release -> pwmOut=0, duty=0, gain=0, busy=0, periodStart=1 in the first post-reset cycle, then again every 128 cycles.
REQ-027 Ramp-up: dacCount=64, enable=1 held -> first boundary gives gain=1, duty=4; second gives gain=2, duty=8; the 16th gives gain=16, duty=64, state PLAYING, and pwmOut is high 64 of 128 cycles.
REQ-028 Ramp-down: dacCount=127 in PLAYING, enable dropped -> next boundary gives gain=15, duty=119; 15 boundaries later gain=0, duty=0, busy=0.
REQ-029 Reversal: in RAMP_UP at gain=5, enable=0 -> next boundary gives gain=4 in RAMP_DOWN; enable=1 again -> next boundary gives gain=5 in RAMP_UP.
REQ-030 Mid-period isolation: dacCount changed 10->120 at cnt=50 while PLAYING -> duty stays 10 until the next boundary, then becomes 120.
REQ-031 Mid-operation reset: rst=1 for 1 cycle while PLAYING at cnt=70 -> next cycle has cnt=0, gain=0, duty=0, pwmOut=0 and busy=0.
